if_fetch_ctrl: RTL and testbench

- Fetch sequencer for the pipelined CPU front end.
- Owns the fetch PC and drives the instruction-memory request/acknowledge handshake, with at most one request outstanding.
- Buffers returned instructions in a 2-entry FIFO for decode.
- Applies branch/jump redirects from execute, discarding wrong-path responses that are in flight.

---
 rtl/if_fetch_ctrl_if.sv | 22 ++
 rtl/if_fetch_ctrl.sv | 176 +++++++++++++++++
 tb/tb_if_fetch_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_ctrl_if.sv
// Instruction-memory request/acknowledge bundle.
// One request outstanding at a time; the fetch controller is the master.
interface if_fetch_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, runs the imem handshake,
// buffers instructions in a 2-entry FIFO and handles redirects.
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_en_i,
    input  logic                  redirect_valid_i,
    input  logic [31:0]           redirect_pc_i,
    if_fetch_ctrl_if.master       imem,
    output logic                  if_valid_o,
    output logic [31:0]           if_inst_o,
    output logic [31:0]           if_pc_o,
    output logic [31:0]           if_pc4_o,
    input  logic                  id_ready_i,
    output logic [31:0]           bubble_cnt_o
);

    typedef enum logic {
        S_RUN,
        S_DISCARD
    } state_e;

    state_e      state_q;
    state_e      state_d;

    logic        req_q;
    logic        req_d;
    logic [31:0] addr_q;
    logic [31:0] addr_d;
    logic [31:0] fetch_pc_q;
    logic [31:0] fetch_pc_d;
    logic [1:0]  cnt_q;
    logic [1:0]  cnt_d;
    logic        wr_ptr_q;
    logic        rd_ptr_q;
    logic [31:0] inst_q [2];
    logic [31:0] pc_q   [2];
    logic [31:0] bubble_q;

    logic        ack;
    logic        outstanding;
    logic        discard;
    logic        push;
    logic        pop;
    logic        launch;
    logic        head_valid;
    logic        bubble;

    assign ack         = req_q & imem.imem_ack;
    assign outstanding = req_q & ~imem.imem_ack;
    assign head_valid  = (cnt_q != 2'd0);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a redirect with the request still open must eat its reply
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_RUN: begin
                if (redirect_valid_i && outstanding) begin
                    state_d = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (!outstanding) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    // Outputs of the FSM
    always_comb begin
        discard = 1'b0;
        unique case (state_q)
            S_RUN:     discard = 1'b0;
            S_DISCARD: discard = 1'b1;
            default:   discard = 1'b0;
        endcase
    end

    assign push = ack & ~discard & ~redirect_valid_i;
    assign pop  = head_valid & id_ready_i & ~redirect_valid_i;

    always_comb begin
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
        if (redirect_valid_i) begin
            cnt_d = 2'd0;
        end
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid_i) begin
            fetch_pc_d = redirect_pc_i & ~32'h3;
        end else if (push) begin
            fetch_pc_d = addr_q + 32'd4;
        end
    end

    // Launch looks at the post-update count and PC so zero-wait memory streams
    assign launch = (cnt_d < 2'd2) & fetch_en_i & ~outstanding;

    always_comb begin
        req_d  = launch | outstanding;
        addr_d = launch ? fetch_pc_d : addr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            fetch_pc_q <= RESET_PC;
            cnt_q      <= 2'd0;
        end else begin
            req_q      <= req_d;
            addr_q     <= addr_d;
            fetch_pc_q <= fetch_pc_d;
            cnt_q      <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            inst_q[0] <= NOP_INST;
            inst_q[1] <= NOP_INST;
            pc_q[0]   <= 32'd0;
            pc_q[1]   <= 32'd0;
        end else if (redirect_valid_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            if (push) begin
                inst_q[wr_ptr_q] <= imem.imem_rdata;
                pc_q[wr_ptr_q]   <= addr_q;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    assign bubble = fetch_en_i & id_ready_i & ~head_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_q <= 32'd0;
        end else if (bubble && (bubble_q != 32'hFFFF_FFFF)) begin
            bubble_q <= bubble_q + 32'd1;
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;

    assign if_valid_o   = head_valid;
    assign if_inst_o    = head_valid ? inst_q[rd_ptr_q] : NOP_INST;
    assign if_pc_o      = head_valid ? pc_q[rd_ptr_q] : 32'd0;
    assign if_pc4_o     = if_pc_o + 32'd4;
    assign bubble_cnt_o = bubble_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl with a wait-state memory model.
// Timeline comments name edges E0.. counted from reset release.
module tb_if_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic [31:0] bubble_cnt;

    int          checks = 0;
    int          errors = 0;
    int          wait_cfg = 0;
    logic [3:0]  wcnt = 4'd0;

    if_fetch_ctrl_if imem ();

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    assign imem.imem_ack   = imem.imem_req && (int'(wcnt) >= wait_cfg);
    assign imem.imem_rdata = word_at(imem.imem_addr);

    always @(posedge clk) begin
        if (!imem.imem_req || imem.imem_ack) wcnt <= 4'd0;
        else wcnt <= wcnt + 4'd1;
    end

    if_fetch_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .fetch_en_i       (fetch_en),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .imem             (imem),
        .if_valid_o       (if_valid),
        .if_inst_o        (if_inst),
        .if_pc_o          (if_pc),
        .if_pc4_o         (if_pc4),
        .id_ready_i       (id_ready),
        .bubble_cnt_o     (bubble_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic head(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, {31'd0, if_valid}, 32'd1);
        chk({tag, "_pc"}, if_pc, pc);
        chk({tag, "_pc4"}, if_pc4, pc + 32'd4);
        chk({tag, "_inst"}, if_inst, word_at(pc));
    endtask

    task automatic req(input string tag, input logic r,
                       input logic [31:0] a);
        chk({tag, "_req"}, {31'd0, imem.imem_req}, {31'd0, r});
        if (r) chk({tag, "_addr"}, imem.imem_addr, a);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        id_ready       = 1'b0;
        #3;
        req("rst", 1'b0, 32'd0);
        chk("rst_addr", imem.imem_addr, 32'd0);
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_inst", if_inst, 32'h0000_0013);
        chk("rst_pc", if_pc, 32'd0);
        chk("rst_pc4", if_pc4, 32'd4);
        chk("rst_bub", bubble_cnt, 32'd0);

        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        fetch_en = 1'b1;
        id_ready = 1'b1;

        // zero-wait streaming
        tick();  // E0
        req("e0", 1'b1, 32'h0);
        chk("e0_valid", {31'd0, if_valid}, 32'd0);
        chk("e0_bub", bubble_cnt, 32'd1);
        tick();  // E1
        head("e1", 32'h0);
        req("e1", 1'b1, 32'h4);
        chk("e1_bub", bubble_cnt, 32'd2);
        tick();  // E2
        head("e2", 32'h4);
        req("e2", 1'b1, 32'h8);
        tick();  // E3
        head("e3", 32'h8);
        req("e3", 1'b1, 32'hC);

        // decode stall fills the FIFO
        id_ready = 1'b0;
        tick();  // E4
        req("e4", 1'b0, 32'h0);
        head("e4", 32'h8);
        tick_n(8);  // E12
        req("e12", 1'b0, 32'h0);
        head("e12", 32'h8);
        chk("e12_bub", bubble_cnt, 32'd2);
        id_ready = 1'b1;
        tick();  // E13
        req("e13", 1'b1, 32'h10);
        head("e13", 32'hC);
        tick();  // E14
        head("e14", 32'h10);
        req("e14", 1'b1, 32'h14);

        // three wait states
        wait_cfg = 3;
        tick_n(3);  // E17
        req("e17", 1'b1, 32'h14);
        chk("e17_valid", {31'd0, if_valid}, 32'd0);
        tick();  // E18
        head("e18", 32'h14);
        req("e18", 1'b1, 32'h18);
        chk("e18_bub", bubble_cnt, 32'd5);
        tick_n(4);  // E22
        head("e22", 32'h18);
        req("e22", 1'b1, 32'h1C);
        chk("e22_bub", bubble_cnt, 32'd8);

        // redirect while the request is waiting
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();  // E23
        redirect_valid = 1'b0;
        chk("e23_valid", {31'd0, if_valid}, 32'd0);
        req("e23", 1'b1, 32'h1C);
        tick_n(2);  // E25
        req("e25", 1'b1, 32'h1C);
        tick();  // E26
        req("e26", 1'b1, 32'h100);
        chk("e26_valid", {31'd0, if_valid}, 32'd0);
        tick_n(4);  // E30
        head("e30", 32'h100);
        req("e30", 1'b1, 32'h104);
        chk("e30_bub", bubble_cnt, 32'd15);

        // redirect in the ack cycle, unaligned target
        wait_cfg       = 0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        tick();  // E31
        redirect_valid = 1'b0;
        chk("e31_valid", {31'd0, if_valid}, 32'd0);
        req("e31", 1'b1, 32'h200);
        tick();  // E32
        head("e32", 32'h200);
        req("e32", 1'b1, 32'h204);

        // second redirect while discarding
        wait_cfg       = 2;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h250;
        tick();  // E33
        redirect_pc = 32'h300;
        tick();  // E34
        redirect_valid = 1'b0;
        req("e34", 1'b1, 32'h204);
        chk("e34_valid", {31'd0, if_valid}, 32'd0);
        tick();  // E35
        req("e35", 1'b1, 32'h300);
        chk("e35_valid", {31'd0, if_valid}, 32'd0);
        tick_n(3);  // E38
        head("e38", 32'h300);
        req("e38", 1'b1, 32'h304);

        // fetch disabled: outstanding request still lands
        fetch_en = 1'b0;
        tick_n(3);  // E41
        head("e41", 32'h304);
        req("e41", 1'b0, 32'h0);
        tick();  // E42
        chk("e42_valid", {31'd0, if_valid}, 32'd0);
        req("e42", 1'b0, 32'h0);

        // fill FIFO, then reset
        fetch_en = 1'b1;
        id_ready = 1'b0;
        wait_cfg = 0;
        tick();  // E43
        req("e43", 1'b1, 32'h308);
        tick();  // E44
        req("e44", 1'b1, 32'h30C);
        head("e44", 32'h308);
        tick();  // E45
        req("e45", 1'b0, 32'h0);
        head("e45", 32'h308);

        rst_n = 1'b0;
        #1;
        req("ar", 1'b0, 32'h0);
        chk("ar_addr", imem.imem_addr, 32'h0);
        chk("ar_valid", {31'd0, if_valid}, 32'd0);
        chk("ar_inst", if_inst, 32'h0000_0013);
        chk("ar_bub", bubble_cnt, 32'd0);
        id_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        req("rr", 1'b1, 32'h0);
        chk("rr_bub", bubble_cnt, 32'd1);
        tick();
        head("rr", 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
